// File: rtl/half_adder_bist.sv
// half_adder_bist: exhaustive-sweep self-test engine driving and checking a half adder
module half_adder_bist #(
  parameter int NUM_PASSES = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_seen,
  output logic [1:0]       fail_vec
);
  localparam int PW = $clog2(NUM_PASSES + 1);
  localparam logic [PW-1:0] LAST = PW'(NUM_PASSES - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  state_t state;
  logic [PW-1:0] pcnt;
  logic mism;
  assign mism = (sum != (a ^ b)) | (carry != (a & b));
  assign busy = (state == SETTLE) || (state == CHECK);
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pcnt      <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_seen <= 1'b0;
      fail_vec  <= 2'b00;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          {a, b}    <= 2'b00;
          pcnt      <= '0;
          pass      <= 1'b0;
          err_count <= '0;
          fail_seen <= 1'b0;
          fail_vec  <= 2'b00;
          state     <= SETTLE;
        end
        SETTLE: state <= CHECK;
        CHECK: begin
          if (mism) begin
            err_count <= (err_count == '1) ? err_count : err_count + 1'b1;
            if (!fail_seen) begin
              fail_seen <= 1'b1;
              fail_vec  <= {a, b};
            end
          end
          {a, b} <= {a, b} + 2'b01;
          state  <= SETTLE;
          if ({a, b} == 2'b11) begin
            if (pcnt < LAST) begin
              pcnt <= pcnt + 1'b1;
            end else begin
              pass  <= !(fail_seen || mism);
              state <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_half_adder_bist.sv
// tb_half_adder_bist: drives two BIST instances against table-defined (possibly faulty) adders
module tb_half_adder_bist;
  logic clk = 0, rst = 1, start1 = 0, start2 = 0;
  logic a1, b1, sum1, carry1, busy1, done1, pass1, fs1;
  logic a2, b2, sum2, carry2, busy2, done2, pass2, fs2;
  logic [7:0] err1;
  logic [1:0] err2, fv1, fv2;
  logic [1:0] ft1 [4];
  logic [1:0] ft2 [4];
  int compares = 0, fails = 0;
  always #5 clk = ~clk;
  assign {sum1, carry1} = ft1[{a1, b1}];
  assign {sum2, carry2} = ft2[{a2, b2}];
  half_adder_bist dut1 (.clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .sum(sum1),
    .carry(carry1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_seen(fs1), .fail_vec(fv1));
  half_adder_bist #(.NUM_PASSES(2), .ERR_W(2)) dut2 (.clk(clk), .rst(rst), .start(start2),
    .a(a2), .b(b2), .sum(sum2), .carry(carry2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_seen(fs2), .fail_vec(fv2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [1:0] good(input int v);
    int x = v / 2, y = v % 2;
    return 2'((x ^ y) * 2 + (x & y));
  endfunction
  task automatic set_good(input int s);
    for (int v = 0; v < 4; v++) if (s == 1) ft1[v] = good(v); else ft2[v] = good(v);
  endtask
  // One accepted run on instance s; noise pulses start while busy/done to prove it is ignored
  task automatic run(input int s, input bit noise);
    int np = (s == 1) ? 1 : 2, emax = (s == 1) ? 255 : 3, e = 0, fv = 0, k;
    bit fs = 0;
    logic [1:0] t;
    for (int p = 0; p < np; p++)
      for (int v = 0; v < 4; v++) begin
        t = (s == 1) ? ft1[v] : ft2[v];
        if (t != good(v)) begin
          e++;
          if (!fs) begin fs = 1; fv = v; end
        end
      end
    if (s == 1) start1 = 1; else start2 = 1;
    step();
    for (k = 1; k <= 8 * np; k++) begin
      if (s == 1) start1 = noise & $urandom_range(0, 1); else start2 = noise & $urandom_range(0, 1);
      chk("busy_run", (s == 1) ? busy1 : busy2, 1);
      chk("done_early", (s == 1) ? done1 : done2, 0);
      chk("ab_seq", (s == 1) ? {a1, b1} : {a2, b2}, ((k - 1) / 2) % 4);
      step();
    end
    chk("done_pulse", (s == 1) ? done1 : done2, 1);
    chk("busy_done", (s == 1) ? busy1 : busy2, 0);
    chk("ab_done", (s == 1) ? {a1, b1} : {a2, b2}, 0);
    chk("pass", (s == 1) ? pass1 : pass2, e == 0);
    chk("err_count", (s == 1) ? err1 : {6'd0, err2}, (e > emax) ? emax : e);
    chk("fail_seen", (s == 1) ? fs1 : fs2, fs);
    chk("fail_vec", (s == 1) ? fv1 : fv2, fv);
    step();
    if (s == 1) start1 = 0; else start2 = 0;
    chk("done_once", (s == 1) ? done1 : done2, 0);
    step();
    chk("idle_after", (s == 1) ? busy1 : busy2, 0);
    chk("hold_err", (s == 1) ? err1 : {6'd0, err2}, (e > emax) ? emax : e);
    chk("hold_vec", (s == 1) ? fv1 : fv2, fv);
  endtask
  initial begin
    set_good(1);
    set_good(2);
    step();
    step();
    rst = 0;
    chk("rst_ab", {a1, b1, a2, b2}, 0);
    chk("rst_busy_done", {busy1, done1, busy2, done2}, 0);
    chk("rst_results", {pass1, fs1, fv1, err1}, 0);
    run(1, 0);
    ft1[3] = 2'b00;
    run(1, 0);
    for (int v = 0; v < 4; v++) ft2[v] = good(v) ^ 2'b10;
    run(2, 0);
    for (int v = 0; v < 4; v++) ft1[v] = {good(v)[0], good(v)[1]};
    run(1, 1);
    set_good(1);
    start1 = 1;
    step();
    start1 = 0;
    for (int k = 1; k < 5; k++) step();
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_state", {a1, b1, busy1, done1, pass1, fs1, fv1, err1}, 0);
    for (int k = 0; k < 12; k++) begin
      chk("mid_rst_nodone", done1, 0);
      step();
    end
    run(1, 0);
    start1 = 1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 30) start1 = 0;
      chk("held_done", done1, (k == 9 || k == 19 || k == 29));
    end
    step();
    chk("held_stop", busy1, 0);
    for (int r = 0; r < 6; r++) begin
      for (int v = 0; v < 4; v++) begin
        ft1[v] = ($urandom_range(0, 1) == 1) ? good(v) : 2'($urandom);
        ft2[v] = ($urandom_range(0, 1) == 1) ? good(v) : 2'($urandom);
      end
      run(1, r[0]);
      run(2, r[1]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule

// File: doc/half_adder_bist.md
# half_adder_bist

- Built-in self-test engine for the half adder: it is the driving and checking end of the half adder's a/b → sum/carry interface.
- On `start` it applies the exhaustive operand sweep {a,b} = 00, 01, 10, 11 to the adder. It samples `sum`/`carry`, compares them against expected a^b / a&b, counts mismatches and records the first failing vector.
- It sits beside the half adder instance, replacing a simulation-only stimulus/monitor bench with synthesizable hardware.

## Interface
Parameters:
- `NUM_PASSES`, default 1: number of full 4-vector sweeps per run (≥1).
- `ERR_W`, default 8: width of the mismatch counter.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: run request, sampled only in IDLE.
- `a` out 1: operand to adder.
- `b` out 1: operand to adder.
- `sum` in 1: adder sum response.
- `carry` in 1: adder carry response.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse at end of run.
- `pass` out 1: 1 if the run had zero mismatches; valid from `done`, held until next accepted start.
- `err_count` out ERR_W: mismatched vectors this run, saturating.
- `fail_seen` out 1: at least one mismatch this run.
- `fail_vec` out 2: {a,b} of the first mismatching vector; 00 if none.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE, `start`=1 at the edge:
  - load {a,b}=00 and clear pass counter.
  - clear `err_count`, `fail_seen`, `fail_vec`, `pass`.
  - go to SETTLE.
- SETTLE: hold a/b for one cycle so the combinational adder settles; go to CHECK.
- CHECK, at the edge ending the cycle:
  - Compare `sum` with a^b and `carry` with a&b. A vector counts one error if either bit mismatches.
  - On a mismatch with `fail_seen`=0: set `fail_seen`, capture {a,b} into `fail_vec`.
  - `err_count` increments by 1 per mismatching vector, saturating at 2^ERR_W−1.
  - Vector 11 with pass counter < NUM_PASSES−1: {a,b}→00, increment pass counter, go to SETTLE.
  - Vector 11 on the last pass: {a,b}→00, `pass`←(no mismatch this run, including this vector), go to DONE.
  - Otherwise: {a,b} increments as a 2-bit value, go to SETTLE.
- DONE: `done`=1 for exactly one cycle; unconditionally go to IDLE. `start` is not sampled in DONE.
- `start` in SETTLE/CHECK/DONE is ignored; it is not queued.
- Results (`pass`, `err_count`, `fail_seen`, `fail_vec`) hold their values in IDLE until the next accepted start.
- `fail_vec` is never overwritten after the first capture within a run, including on later passes.

## Timing
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_seen=0, fail_vec=00; state IDLE; pass counter 0.
- Reset asserted mid-run aborts the sweep at the next edge to the reset values; no `done` pulse.
- `busy` is a decode of SETTLE|CHECK, so it is registered-state driven.
- Start accepted at edge E0:
  - `busy` is high for cycles 1..8·NUM_PASSES after E0.
  - `done` is high in cycle 8·NUM_PASSES+1.
  - The earliest next start can be accepted at the edge after the DONE cycle.
- Each vector occupies exactly 2 cycles (SETTLE then CHECK).
- a/b are registered outputs that change only at edges leaving IDLE or CHECK.
- With `start` held high continuously, runs repeat back-to-back with one IDLE cycle between DONE and the next SETTLE.
- `pass`, `err_count`, `fail_vec` are stable in the `done` cycle.

## Test plan
- Correct half adder, defaults, one start pulse → a/b sequence 00,01,10,11 each for 2 cycles; done in cycle 9; pass=1, err_count=0, fail_seen=0, fail_vec=00.
- Adder with carry stuck-at-0 → err_count=1, fail_seen=1, fail_vec=11, pass=0.
- Adder with inverted sum, NUM_PASSES=2, ERR_W=2 → err_count saturates at 3 (raw 8), fail_vec=00, done in cycle 17.
- Reset asserted in cycle 5 of a run → next cycle all outputs at reset values, no done. A new start then completes with pass=1.
- Start pulsed during busy and during DONE → ignored; exactly one done per accepted start. Start held high for 30 cycles with a correct adder → done pulses in cycles 9, 19, 29.
- Sum and carry swapped (sum=a&b, carry=a^b) → mismatches on 01, 10, 11; err_count=3, fail_vec=01.
